soc_mem_arbiter: RTL and testbench

SOC_MEM_ARBITER -- requirements
Module: soc_mem_arbiter

---
 rtl/soc_pkg.sv | 14 +
 rtl/soc_mem_arbiter.sv | 114 +++++++++++
 tb/tb_soc_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared types for the SoC memory path: arbiter FSM states and master identifiers.
package soc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_VPU = 1'b1
  } mst_t;

endpackage

// File: rtl/soc_mem_arbiter.sv
// Two-master (CPU data port, VPU XIF memory port) arbiter for a single-port
// data memory with one-cycle read latency and at most one access in flight.
module soc_mem_arbiter
  import soc_pkg::*;
#(
  parameter int MEM_WORDS = 16384
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        vpu_valid_i,
  output logic        vpu_ready_o,
  input  logic [31:0] vpu_addr_i,
  input  logic        vpu_we_i,
  input  logic [3:0]  vpu_be_i,
  input  logic [31:0] vpu_wdata_i,
  output logic        vpu_result_valid_o,
  output logic [31:0] vpu_rdata_o,
  output logic        vpu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output state_t      dbg_state_o
);

  // Handshake: a request is accepted in the cycle its gnt/ready is high;
  // the single response follows exactly one cycle later on the matching valid.

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  state_t      state;
  mst_t        last_grant;
  mst_t        resp_mst;
  logic        resp_rd;
  logic        resp_bad;

  mst_t        sel;
  logic        grant;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        oor;
  logic        mis;
  logic [31:0] resp_data;

  always_comb begin
    sel = MST_CPU;
    // On a tie the master that did not win last time goes first.
    if (vpu_valid_i && (!data_req_i || last_grant == MST_CPU)) sel = MST_VPU;

    grant     = (state == IDLE) && !rst_i && (data_req_i || vpu_valid_i);
    sel_we    = (sel == MST_VPU) ? vpu_we_i    : data_we_i;
    sel_be    = (sel == MST_VPU) ? vpu_be_i    : data_be_i;
    sel_addr  = (sel == MST_VPU) ? vpu_addr_i  : data_addr_i;
    sel_wdata = (sel == MST_VPU) ? vpu_wdata_i : data_wdata_i;

    oor = {2'b00, sel_addr[31:2]} >= MEM_WORDS_L;
    mis = (sel == MST_VPU) && (sel_addr[1:0] != 2'b00);
  end

  assign data_gnt_o  = grant && (sel == MST_CPU);
  assign vpu_ready_o = grant && (sel == MST_VPU);

  // Bad accesses are still accepted but never reach the memory.
  assign mem_req_o   = grant && !oor && !mis;
  assign mem_we_o    = grant && sel_we;
  assign mem_be_o    = grant ? sel_be          : 4'h0;
  assign mem_addr_o  = grant ? sel_addr[31:2]  : 30'h0;
  assign mem_wdata_o = grant ? sel_wdata       : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= MST_VPU;
      resp_mst   <= MST_CPU;
      resp_rd    <= 1'b0;
      resp_bad   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= RESP;
            last_grant <= sel;
            resp_mst   <= sel;
            resp_rd    <= !sel_we;
            resp_bad   <= oor || mis;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_data          = (resp_rd && !resp_bad) ? mem_rdata_i : 32'h0;
  assign data_rvalid_o      = (state == RESP) && (resp_mst == MST_CPU);
  assign vpu_result_valid_o = (state == RESP) && (resp_mst == MST_VPU);
  assign data_rdata_o       = data_rvalid_o      ? resp_data : 32'h0;
  assign vpu_rdata_o        = vpu_result_valid_o ? resp_data : 32'h0;
  assign vpu_err_o          = vpu_result_valid_o && resp_bad;
  assign dbg_state_o        = state;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter with a behavioural one-cycle-latency memory.
module tb_soc_mem_arbiter;
  import soc_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        vpu_valid_i, vpu_ready_o, vpu_we_i;
  logic [31:0] vpu_addr_i, vpu_wdata_i;
  logic [3:0]  vpu_be_i;
  logic        vpu_result_valid_o, vpu_err_o;
  logic [31:0] vpu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  state_t      dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];

  soc_mem_arbiter #(.MEM_WORDS(16384)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .vpu_valid_i(vpu_valid_i), .vpu_ready_o(vpu_ready_o), .vpu_addr_i(vpu_addr_i),
    .vpu_we_i(vpu_we_i), .vpu_be_i(vpu_be_i), .vpu_wdata_i(vpu_wdata_i),
    .vpu_result_valid_o(vpu_result_valid_o), .vpu_rdata_o(vpu_rdata_o), .vpu_err_o(vpu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // memory model: read data valid one cycle after the request
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[13:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o[13:0]];
      end
    end
  end

  task automatic clear_inputs();
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    vpu_valid_i = 1'b0; vpu_we_i = 1'b0; vpu_be_i = 4'h0; vpu_addr_i = 32'h0; vpu_wdata_i = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    data_req_i = 1'b1; vpu_valid_i = 1'b1; data_addr_i = 32'h100; vpu_addr_i = 32'h200;
    #1;
    checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", data_gnt_o); end
    checks++; if (vpu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", vpu_ready_o); end
    checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 30'h0) begin errors++; $display("FAIL reset_mem got req %b addr %h exp 0 0", mem_req_o, mem_addr_o); end
    checks++; if ({data_rvalid_o, vpu_result_valid_o, vpu_err_o} !== 3'b000) begin errors++; $display("FAIL reset_valids got %b exp 000", {data_rvalid_o, vpu_result_valid_o, vpu_err_o}); end
    checks++; if (dbg_state_o !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dbg_state_o); end
    clear_inputs();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // both masters hold requests; grants must alternate CPU, VPU, CPU, VPU
  task automatic test_round_robin();
    logic exp_vpu;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_i);
      data_req_i = 1'b1; data_addr_i = 32'h100;
      vpu_valid_i = 1'b1; vpu_addr_i = 32'h200;
      #1;
      exp_vpu = ((k / 2) % 2) == 1;
      if (k % 2 == 0) begin
        checks++; if (data_gnt_o !== !exp_vpu || vpu_ready_o !== exp_vpu) begin errors++; $display("FAIL rr_grant k=%0d got gnt %b rdy %b exp gnt %b rdy %b", k, data_gnt_o, vpu_ready_o, !exp_vpu, exp_vpu); end
      end else begin
        checks++; if (data_gnt_o !== 1'b0 || vpu_ready_o !== 1'b0) begin errors++; $display("FAIL rr_resp_nogrant k=%0d got gnt %b rdy %b exp 0 0", k, data_gnt_o, vpu_ready_o); end
        if (exp_vpu) begin
          checks++; if (vpu_result_valid_o !== 1'b1 || data_rvalid_o !== 1'b0 || vpu_rdata_o !== 32'hA5A50128) begin errors++; $display("FAIL rr_vpu_resp k=%0d got v %b c %b d %h exp 1 0 a5a50128", k, vpu_result_valid_o, data_rvalid_o, vpu_rdata_o); end
        end else begin
          checks++; if (data_rvalid_o !== 1'b1 || vpu_result_valid_o !== 1'b0 || data_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_cpu_resp k=%0d got c %b v %b d %h exp 1 0 deadbeef", k, data_rvalid_o, vpu_result_valid_o, data_rdata_o); end
        end
      end
    end
    @(negedge clk_i);
    clear_inputs();
  endtask

  task automatic test_cpu_read();
    @(negedge clk_i);
    data_req_i = 1'b1; data_addr_i = 32'h100;
    #1;
    checks++; if (data_gnt_o !== 1'b1 || vpu_ready_o !== 1'b0) begin errors++; $display("FAIL cpu_rd_gnt got %b %b exp 1 0", data_gnt_o, vpu_ready_o); end
    checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 30'd64) begin errors++; $display("FAIL cpu_rd_mem got req %b we %b addr %h exp 1 0 40", mem_req_o, mem_we_o, mem_addr_o); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rd_resp got %b %h exp 1 deadbeef", data_rvalid_o, data_rdata_o); end
    checks++; if (vpu_result_valid_o !== 1'b0 || vpu_err_o !== 1'b0 || vpu_rdata_o !== 32'h0) begin errors++; $display("FAIL cpu_rd_vpu_quiet got %b %b %h exp 0 0 0", vpu_result_valid_o, vpu_err_o, vpu_rdata_o); end
  endtask

  task automatic test_vpu_write_read();
    @(negedge clk_i);
    vpu_valid_i = 1'b1; vpu_we_i = 1'b1; vpu_be_i = 4'hF; vpu_addr_i = 32'h200; vpu_wdata_i = 32'h12345678;
    #1;
    checks++; if (vpu_ready_o !== 1'b1 || mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin errors++; $display("FAIL vpu_wr_acc got rdy %b req %b we %b exp 1 1 1", vpu_ready_o, mem_req_o, mem_we_o); end
    checks++; if (mem_be_o !== 4'hF || mem_addr_o !== 30'd128 || mem_wdata_o !== 32'h12345678) begin errors++; $display("FAIL vpu_wr_mux got be %h addr %h wd %h exp f 80 12345678", mem_be_o, mem_addr_o, mem_wdata_o); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++; if (vpu_result_valid_o !== 1'b1 || vpu_rdata_o !== 32'h0 || vpu_err_o !== 1'b0) begin errors++; $display("FAIL vpu_wr_resp got %b %h %b exp 1 0 0", vpu_result_valid_o, vpu_rdata_o, vpu_err_o); end
    @(negedge clk_i);
    vpu_valid_i = 1'b1; vpu_addr_i = 32'h200;
    #1;
    checks++; if (vpu_ready_o !== 1'b1 || mem_req_o !== 1'b1) begin errors++; $display("FAIL vpu_rd_acc got %b %b exp 1 1", vpu_ready_o, mem_req_o); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++; if (vpu_result_valid_o !== 1'b1 || vpu_rdata_o !== 32'h12345678 || vpu_err_o !== 1'b0) begin errors++; $display("FAIL vpu_rd_resp got %b %h %b exp 1 12345678 0", vpu_result_valid_o, vpu_rdata_o, vpu_err_o); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk_i);
    vpu_valid_i = 1'b1; vpu_addr_i = 32'h10000;
    #1;
    checks++; if (vpu_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL oor_acc got rdy %b req %b exp 1 0", vpu_ready_o, mem_req_o); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++; if (vpu_result_valid_o !== 1'b1 || vpu_err_o !== 1'b1 || vpu_rdata_o !== 32'h0) begin errors++; $display("FAIL oor_resp got %b %b %h exp 1 1 0", vpu_result_valid_o, vpu_err_o, vpu_rdata_o); end
    @(negedge clk_i);
    #1;
    checks++; if (vpu_result_valid_o !== 1'b0 || vpu_err_o !== 1'b0) begin errors++; $display("FAIL oor_err_clear got %b %b exp 0 0", vpu_result_valid_o, vpu_err_o); end
  endtask

  task automatic test_misaligned();
    @(negedge clk_i);
    vpu_valid_i = 1'b1; vpu_addr_i = 32'h202;
    #1;
    checks++; if (vpu_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL mis_vpu_acc got %b %b exp 1 0", vpu_ready_o, mem_req_o); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++; if (vpu_result_valid_o !== 1'b1 || vpu_err_o !== 1'b1 || vpu_rdata_o !== 32'h0) begin errors++; $display("FAIL mis_vpu_resp got %b %b %h exp 1 1 0", vpu_result_valid_o, vpu_err_o, vpu_rdata_o); end
    @(negedge clk_i);
    data_req_i = 1'b1; data_addr_i = 32'h202;
    #1;
    checks++; if (data_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 30'd128) begin errors++; $display("FAIL mis_cpu_acc got %b %b %h exp 1 1 80", data_gnt_o, mem_req_o, mem_addr_o); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h12345678 || vpu_err_o !== 1'b0) begin errors++; $display("FAIL mis_cpu_resp got %b %h %b exp 1 12345678 0", data_rvalid_o, data_rdata_o, vpu_err_o); end
  endtask

  task automatic test_reset_during_resp();
    @(negedge clk_i);
    data_req_i = 1'b1; data_addr_i = 32'h100;
    #1;
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL rdr_gnt got %b exp 1", data_gnt_o); end
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b1;
    #1;
    checks++; if (data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0 || vpu_result_valid_o !== 1'b0) begin errors++; $display("FAIL rdr_dropped got %b %h %b exp 0 0 0", data_rvalid_o, data_rdata_o, vpu_result_valid_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    data_req_i = 1'b1; data_addr_i = 32'h100;
    vpu_valid_i = 1'b1; vpu_addr_i = 32'h200;
    #1;
    checks++; if (dbg_state_o !== IDLE) begin errors++; $display("FAIL rdr_state got %0d exp IDLE", dbg_state_o); end
    checks++; if (data_gnt_o !== 1'b1 || vpu_ready_o !== 1'b0) begin errors++; $display("FAIL rdr_tie got gnt %b rdy %b exp 1 0", data_gnt_o, vpu_ready_o); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rdr_resp got %b %h exp 1 deadbeef", data_rvalid_o, data_rdata_o); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[64]  = 32'hDEADBEEF;
    mem[128] = 32'hA5A50128;
    mem_rdata_i = 32'h0;
    clear_inputs();
    rst_i = 1'b1;
    test_reset();
    test_round_robin();
    test_cpu_read();
    test_vpu_write_read();
    test_out_of_range();
    test_misaligned();
    test_reset_during_resp();
    @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
